look_up_key_arb: RTL and testbench

LOOK_UP_KEY_ARB -- requirements
Module: look_up_key_arb

---
 rtl/look_up_key_arb.sv | 210 +++++++++++++++++++++
 tb/tb_look_up_key_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/look_up_key_arb.sv
// ---------------------------------------------------------------------------
// look_up_key_arb
//
// Round-robin arbiter that lets PORT_NUM switch ports share one MAC lookup
// engine. Only one lookup is in flight at a time. A port's key is captured
// when it wins a grant. The key is issued to the lookup manager for one
// cycle, and the lookup result is returned to that port only.
//
// Handshakes:
//   key side    - a port raises i_port_key_vld[p] and holds it until it sees
//                 o_port_key_rdy[p]. The key is taken on the rising edge that
//                 ends the rdy cycle. rdy is one-hot and lasts one cycle. A
//                 port that drops vld before it is granted is never served.
//   lookup side - o_dmac_vld/o_smac_vld pulse together for one cycle. There is
//                 no back-pressure. The key fields stay stable until the next
//                 grant.
//   result side - i_tx_port_vld is a one-cycle strobe. It is honoured only
//                 while a lookup is outstanding (WAIT). The result comes back
//                 as one-cycle one-hot o_port_tx_port_vld with o_port_tx_port.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_port_key_vld/_rdy      per-port request / grant pulse
//   i_port_vlan_id, i_port_{dmac,smac}_hash_key, i_port_{dmac,smac}
//                            per-port key fields; slice p belongs to port p
//   o_vlan_id, o_dmac_port, o_{dmac,smac}_hash_key, o_{dmac,smac},
//   o_dmac_vld, o_smac_vld   key issued to the lookup manager
//   i_tx_port, i_tx_port_vld lookup result; MSB set = local MAC
//   o_port_tx_port(_vld)     result returned to the requesting port
//   o_timeout_cnt            number of lookups that ended by timeout
//   o_state                  current FSM state (debug observation)
//
// Configuration macro: LOOK_UP_TIMEOUT_EN
//   When defined, a lookup that gets no result within TIMEOUT_CYC cycles of
//   entering WAIT returns the flood result {1'b0, ~o_dmac_port}. It also
//   bumps o_timeout_cnt, which saturates. When undefined, WAIT has no time
//   limit and o_timeout_cnt is always 0.
// ---------------------------------------------------------------------------
module look_up_key_arb #(
  parameter int HASH_DATA_WIDTH = 12,
  parameter int PORT_NUM        = 4,
  parameter int TIMEOUT_CYC     = 64
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [PORT_NUM-1:0]               i_port_key_vld,
  output logic [PORT_NUM-1:0]               o_port_key_rdy,
  input  logic [PORT_NUM*12-1:0]            i_port_vlan_id,
  input  logic [PORT_NUM*HASH_DATA_WIDTH-1:0] i_port_dmac_hash_key,
  input  logic [PORT_NUM*HASH_DATA_WIDTH-1:0] i_port_smac_hash_key,
  input  logic [PORT_NUM*48-1:0]            i_port_dmac,
  input  logic [PORT_NUM*48-1:0]            i_port_smac,
  output logic [11:0]                       o_vlan_id,
  output logic [PORT_NUM-1:0]               o_dmac_port,
  output logic [HASH_DATA_WIDTH-1:0]        o_dmac_hash_key,
  output logic [47:0]                       o_dmac,
  output logic                              o_dmac_vld,
  output logic [HASH_DATA_WIDTH-1:0]        o_smac_hash_key,
  output logic [47:0]                       o_smac,
  output logic                              o_smac_vld,
  input  logic [PORT_NUM:0]                 i_tx_port,
  input  logic                              i_tx_port_vld,
  output logic [PORT_NUM:0]                 o_port_tx_port,
  output logic [PORT_NUM-1:0]               o_port_tx_port_vld,
  output logic [15:0]                       o_timeout_cnt,
  output logic [1:0]                        o_state
);

  localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORT_NUM - 1);

  // Reject configurations the pointer arithmetic cannot handle.
  if (PORT_NUM < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("look_up_key_arb: PORT_NUM must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    grant_q;
  logic [PORT_NUM-1:0] grant_oh;
  logic                grant_found;
  logic                expire;
  int                  cand;

  // Round-robin search: the first requesting port at or after rr_ptr wins.
  // The search wraps from PORT_NUM-1 back to 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= PORT_NUM) cand = cand - PORT_NUM;
      if (!grant_found && i_port_key_vld[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = grant_found;
  end

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (grant_found) state_next = S_ISSUE;
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT:   if (i_tx_port_vld || expire) state_next = S_RETURN;
      S_RETURN: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // rdy depends on the live request vector, so it is also gated by reset.
  // That keeps every output at 0 while reset is held.
  always_comb begin
    o_port_key_rdy     = (state == S_IDLE && !i_rst) ? grant_oh : '0;
    o_dmac_vld         = (state == S_ISSUE);
    o_smac_vld         = (state == S_ISSUE);
    o_port_tx_port_vld = (state == S_RETURN) ? o_dmac_port : '0;
    o_state            = state;
  end

  // ---- Key capture, result capture, round-robin pointer ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr          <= '0;
      grant_q         <= '0;
      o_dmac_port     <= '0;
      o_vlan_id       <= '0;
      o_dmac_hash_key <= '0;
      o_smac_hash_key <= '0;
      o_dmac          <= '0;
      o_smac          <= '0;
      o_port_tx_port  <= '0;
    end else begin
      if (state == S_IDLE && grant_found) begin
        grant_q         <= grant_idx;
        o_dmac_port     <= grant_oh;
        o_vlan_id       <= i_port_vlan_id[grant_idx*12 +: 12];
        o_dmac_hash_key <= i_port_dmac_hash_key[grant_idx*HASH_DATA_WIDTH +: HASH_DATA_WIDTH];
        o_smac_hash_key <= i_port_smac_hash_key[grant_idx*HASH_DATA_WIDTH +: HASH_DATA_WIDTH];
        o_dmac          <= i_port_dmac[grant_idx*48 +: 48];
        o_smac          <= i_port_smac[grant_idx*48 +: 48];
      end
      // A real result beats a timeout that expires in the same cycle.
      if (state == S_WAIT && i_tx_port_vld) begin
        o_port_tx_port <= i_tx_port;
      end else if (expire) begin
        o_port_tx_port <= {1'b0, ~o_dmac_port};
      end
      if (state == S_RETURN) begin
        rr_ptr <= (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
      end
    end
  end

`ifdef LOOK_UP_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYC);

  logic [TMR_W-1:0] wait_tmr;

  // WAIT is only ever entered from ISSUE, so clearing the timer in ISSUE
  // clears it on every entry to WAIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_tmr <= '0;
    end else if (state == S_ISSUE) begin
      wait_tmr <= '0;
    end else if (state == S_WAIT && wait_tmr != TMR_LIMIT) begin
      wait_tmr <= wait_tmr + 1'b1;
    end
  end

  assign expire = (state == S_WAIT) && (wait_tmr == TMR_LIMIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_timeout_cnt <= '0;
    end else if (expire && !i_tx_port_vld && o_timeout_cnt != 16'hFFFF) begin
      o_timeout_cnt <= o_timeout_cnt + 1'b1;
    end
  end
`else
  assign expire        = 1'b0;
  assign o_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_look_up_key_arb.sv
// ---------------------------------------------------------------------------
// tb_look_up_key_arb
//
// Directed bench for look_up_key_arb with PORT_NUM=4, HASH_DATA_WIDTH=12 and
// TIMEOUT_CYC=64. Inputs are driven on the falling edge. Checks run 1 ns
// later, and the monitor samples 2 ns after the falling edge. Returned
// results are scored against exp_q. Each entry packs {port strobe, tx_port}.
// ---------------------------------------------------------------------------
module tb_look_up_key_arb;

  localparam int HW   = 12;
  localparam int PN   = 4;
  localparam int TC   = 64;
  localparam int SB_W = 2 * PN + 1;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [PN-1:0]    key_vld;
  logic [PN-1:0]    key_rdy;
  logic [PN*12-1:0] vlan_in;
  logic [PN*HW-1:0] dhash_in, shash_in;
  logic [PN*48-1:0] dmac_in, smac_in;
  logic [11:0]      vlan_id;
  logic [PN-1:0]    dmac_port;
  logic [HW-1:0]    dmac_hash_key, smac_hash_key;
  logic [47:0]      dmac, smac;
  logic             dmac_vld, smac_vld;
  logic [PN:0]      tx_port;
  logic             tx_port_vld;
  logic [PN:0]      port_tx_port;
  logic [PN-1:0]    port_tx_port_vld;
  logic [15:0]      timeout_cnt;
  logic [1:0]       state;

  look_up_key_arb #(
    .HASH_DATA_WIDTH (HW),
    .PORT_NUM        (PN),
    .TIMEOUT_CYC     (TC)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_port_key_vld       (key_vld),
    .o_port_key_rdy       (key_rdy),
    .i_port_vlan_id       (vlan_in),
    .i_port_dmac_hash_key (dhash_in),
    .i_port_smac_hash_key (shash_in),
    .i_port_dmac          (dmac_in),
    .i_port_smac          (smac_in),
    .o_vlan_id            (vlan_id),
    .o_dmac_port          (dmac_port),
    .o_dmac_hash_key      (dmac_hash_key),
    .o_dmac               (dmac),
    .o_dmac_vld           (dmac_vld),
    .o_smac_hash_key      (smac_hash_key),
    .o_smac               (smac),
    .o_smac_vld           (smac_vld),
    .i_tx_port            (tx_port),
    .i_tx_port_vld        (tx_port_vld),
    .o_port_tx_port       (port_tx_port),
    .o_port_tx_port_vld   (port_tx_port_vld),
    .o_timeout_cnt        (timeout_cnt),
    .o_state              (state)
  );

  // ---- scoreboard ----
  int n_tests = 0;
  int n_fail  = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    chk("rdy_onehot0", 64'($onehot0(key_rdy)), 64'd1);
    if (port_tx_port_vld != '0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_strobe", 64'(port_tx_port_vld), 64'd0);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_result", 64'({port_tx_port_vld, port_tx_port}), 64'(e));
      end
    end
  end

  // ---- driver tasks ----
  task automatic wait_rdy(input int budget, output logic [PN-1:0] got);
    got = '0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (key_rdy != '0) got = key_rdy;
      if (got != '0) break;
      @(negedge clk);
    end
    n_tests++;
    assert (got !== '0) else begin
      n_fail++;
      $error("FAIL rdy_wait observed=0x%0h expected=nonzero within %0d cycles", got, budget);
    end
  endtask

  // One full lookup: request, grant check, issue check, result in the first
  // WAIT cycle, return check. Ends on the falling edge of the next IDLE cycle.
  task automatic serve(input logic [PN-1:0] req, input logic [PN-1:0] exp_grant,
                       input logic [PN:0] res, input string tag);
    logic [PN-1:0] got;
    key_vld = req;
    wait_rdy(8, got);
    chk({tag, "_grant"}, 64'(got), 64'(exp_grant));
    @(negedge clk);
    key_vld = key_vld & ~got;
    #1;
    chk({tag, "_dmac_vld"}, 64'(dmac_vld), 64'd1);
    chk({tag, "_smac_vld"}, 64'(smac_vld), 64'd1);
    chk({tag, "_dmac_port"}, 64'(dmac_port), 64'(exp_grant));
    @(negedge clk);
    tx_port     = res;
    tx_port_vld = 1'b1;
    exp_q.push_back({exp_grant, res});
    @(negedge clk);
    tx_port_vld = 1'b0;
    #1;
    chk({tag, "_ret_vld"}, 64'(port_tx_port_vld), 64'(exp_grant));
    chk({tag, "_ret_port"}, 64'(port_tx_port), 64'(res));
    @(negedge clk);
  endtask

  logic [PN-1:0] got;

  initial begin
    // per-port key fields: distinct, recognisable patterns
    for (int p = 0; p < PN; p++) begin
      vlan_in[p*12 +: 12]  = 12'h100 + 12'(p);
      dhash_in[p*HW +: HW] = 12'hA00 + 12'(p);
      shash_in[p*HW +: HW] = 12'hB00 + 12'(p);
      dmac_in[p*48 +: 48]  = 48'hAA00_0000_0000 + 48'(p);
      smac_in[p*48 +: 48]  = 48'h5500_0000_0000 + 48'(p);
    end
    dmac_in[2*48 +: 48] = 48'h0011_2233_4455;
    rst = 1'b1; key_vld = '0; tx_port = '0; tx_port_vld = 1'b0;

    // ---- reset state, requests ignored while reset is held ----
    repeat (3) @(negedge clk);
    key_vld = 4'b1111;
    #1;
    chk("rst_rdy", 64'(key_rdy), 64'd0);
    chk("rst_dmac_vld", 64'(dmac_vld), 64'd0);
    chk("rst_ret_vld", 64'(port_tx_port_vld), 64'd0);
    chk("rst_ret_port", 64'(port_tx_port), 64'd0);
    chk("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    chk("rst_dmac", 64'(dmac), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    key_vld = '0;
    @(negedge clk);
    rst = 1'b0;

    // ---- single request from port 2 ----
    @(negedge clk);
    key_vld = 4'b0100;
    wait_rdy(4, got);                                   // cycle T
    chk("single_grant", 64'(got), 64'h4);
    @(negedge clk); key_vld = '0; #1;                   // T+1
    chk("single_dmac_vld", 64'(dmac_vld), 64'd1);
    chk("single_smac_vld", 64'(smac_vld), 64'd1);
    chk("single_dmac_port", 64'(dmac_port), 64'h4);
    chk("single_dmac", 64'(dmac), 64'h0011_2233_4455);
    chk("single_vlan", 64'(vlan_id), 64'h102);
    chk("single_dhash", 64'(dmac_hash_key), 64'hA02);
    chk("single_shash", 64'(smac_hash_key), 64'hB02);
    chk("single_smac", 64'(smac), 64'h5500_0000_0002);
    @(negedge clk); #1;                                 // T+2
    chk("single_vld_one_cycle", 64'(dmac_vld), 64'd0);
    chk("single_dmac_hold", 64'(dmac), 64'h0011_2233_4455);
    @(negedge clk);                                     // T+3
    @(negedge clk);                                     // T+4
    tx_port = 5'b00001; tx_port_vld = 1'b1;
    exp_q.push_back({4'b0100, 5'b00001});
    @(negedge clk); tx_port_vld = 1'b0; tx_port = '0; #1; // T+5
    chk("single_ret_vld", 64'(port_tx_port_vld), 64'h4);
    chk("single_ret_port", 64'(port_tx_port), 64'h01);
    @(negedge clk); #1;                                 // T+6
    chk("single_ret_vld_pulse", 64'(port_tx_port_vld), 64'd0);
    chk("single_ret_port_hold", 64'(port_tx_port), 64'h01);

    // ---- local-MAC result for port 1 (rr_ptr = 3) ----
    serve(4'b0010, 4'b0010, 5'b10000, "local");
    // ---- pointer wrap: rr_ptr = 2, ports 0 and 1 ask, port 0 wins ----
    serve(4'b0011, 4'b0001, 5'b00110, "wrap");

    // ---- reset while in WAIT; port 1 dropped its request (rr_ptr = 1) ----
    key_vld = 4'b1000;
    wait_rdy(4, got);                                   // T
    chk("rstw_grant", 64'(got), 64'h8);
    @(negedge clk); key_vld = '0;                       // T+1 ISSUE
    @(negedge clk);                                     // T+2 WAIT
    @(negedge clk); rst = 1'b1; #1;                     // T+3
    chk("rstw_state", 64'(state), 64'd0);
    chk("rstw_dmac_vld", 64'(dmac_vld), 64'd0);
    chk("rstw_dmac_port", 64'(dmac_port), 64'd0);
    chk("rstw_dmac", 64'(dmac), 64'd0);
    chk("rstw_vlan", 64'(vlan_id), 64'd0);
    chk("rstw_ret_port", 64'(port_tx_port), 64'd0);
    @(negedge clk); rst = 1'b0;
    tx_port = 5'b00011; tx_port_vld = 1'b1;             // stray result in IDLE
    @(negedge clk); tx_port_vld = 1'b0; #1;
    chk("rstw_no_strobe", 64'(port_tx_port_vld), 64'd0);
    chk("rstw_stray_ignored", 64'(port_tx_port), 64'd0);
    chk("rstw_idle", 64'(state), 64'd0);
    @(negedge clk);

    // ---- round robin, all ports requesting continuously from port 0 ----
    serve(4'b1111, 4'b0001, 5'h01, "rr0");
    serve(4'b1111, 4'b0010, 5'h02, "rr1");
    serve(4'b1111, 4'b0100, 5'h03, "rr2");
    serve(4'b1111, 4'b1000, 5'h04, "rr3");
    serve(4'b1111, 4'b0001, 5'h05, "rr4");

    // ---- port 2 requests while busy, drops before grant (rr_ptr = 1) ----
    key_vld = 4'b0010;
    wait_rdy(4, got);
    chk("drop_grant", 64'(got), 64'h2);
    @(negedge clk); key_vld = 4'b0100;                  // ISSUE
    @(negedge clk); key_vld = '0;                       // WAIT
    tx_port = 5'b01000; tx_port_vld = 1'b1;
    exp_q.push_back({4'b0010, 5'b01000});
    @(negedge clk); tx_port_vld = 1'b0; #1;             // RETURN
    chk("drop_ret_vld", 64'(port_tx_port_vld), 64'h2);
    repeat (3) @(negedge clk);
    #1;
    chk("drop_idle", 64'(state), 64'd0);
    chk("drop_dmac_port", 64'(dmac_port), 64'h2);
    chk("drop_dmac", 64'(dmac), 64'hAA00_0000_0001);

    // ---- result timeout (rr_ptr = 2, port 3 requests) ----
    @(negedge clk);
    key_vld = 4'b1000;
    wait_rdy(4, got);                                   // T
    chk("to_grant", 64'(got), 64'h8);
    @(negedge clk); key_vld = '0;                       // T+1
`ifdef LOOK_UP_TIMEOUT_EN
    repeat (65) @(negedge clk);                         // T+66: expiry cycle
    #1;
    chk("to_no_early_strobe", 64'(port_tx_port_vld), 64'd0);
    chk("to_cnt_before", 64'(timeout_cnt), 64'd0);
    exp_q.push_back({4'b1000, 5'b00111});
    @(negedge clk); #1;                                 // T+67 = WAIT entry + 65
    chk("to_ret_vld", 64'(port_tx_port_vld), 64'h8);
    chk("to_ret_port", 64'(port_tx_port), 64'h07);
    chk("to_cnt", 64'(timeout_cnt), 64'd1);
    @(negedge clk);
    // result arrives exactly in the expiry cycle (rr_ptr = 0)
    key_vld = 4'b1000;
    wait_rdy(4, got);
    chk("to2_grant", 64'(got), 64'h8);
    @(negedge clk); key_vld = '0;
    repeat (65) @(negedge clk);                         // expiry cycle
    tx_port = 5'b01010; tx_port_vld = 1'b1;
    exp_q.push_back({4'b1000, 5'b01010});
    @(negedge clk); tx_port_vld = 1'b0; #1;
    chk("to2_ret_vld", 64'(port_tx_port_vld), 64'h8);
    chk("to2_ret_port", 64'(port_tx_port), 64'h0A);
    chk("to2_cnt", 64'(timeout_cnt), 64'd1);
    @(negedge clk);
`else
    repeat (100) @(negedge clk);
    #1;
    chk("nto_still_wait", 64'(state), 64'd2);
    chk("nto_no_strobe", 64'(port_tx_port_vld), 64'd0);
    chk("nto_cnt", 64'(timeout_cnt), 64'd0);
    @(negedge clk);
    tx_port = 5'b01100; tx_port_vld = 1'b1;
    exp_q.push_back({4'b1000, 5'b01100});
    @(negedge clk); tx_port_vld = 1'b0; #1;
    chk("nto_ret_vld", 64'(port_tx_port_vld), 64'h8);
    chk("nto_ret_port", 64'(port_tx_port), 64'h0C);
    @(negedge clk);
`endif

    // ---- final report ----
    repeat (2) @(negedge clk);
    #1;
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
